// File: rtl/pb_click_dec.sv
// Push-button click gesture decoder: groups debounced release pulses into
// single, double and triple clicks using an inter-click gap on the 1 ms tick.
module pb_click_dec #(
  parameter int GAP_MS = 300,
  parameter int CNT_W  = 9
) (
  input  logic SYS_CLK,
  input  logic SYS_RST,
  input  logic MS_F,
  input  logic KEY_P,
  output logic SINGLE_P,
  output logic DOUBLE_P,
  output logic TRIPLE_P,
  output logic BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ONE  = 2'd1;
  localparam logic [1:0] TWO  = 2'd2;

  localparam logic [CNT_W-1:0] GAP = CNT_W'(GAP_MS);

  logic [1:0]       state;
  logic [CNT_W-1:0] gap_cnt;
  logic             gap_done;

  // Compare happens before increment, so gap_cnt saturates at GAP.
  assign gap_done = (gap_cnt == GAP);
  assign BUSY     = (state != IDLE);

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      SINGLE_P <= 1'b0;
      DOUBLE_P <= 1'b0;
      TRIPLE_P <= 1'b0;
    end else begin
      SINGLE_P <= 1'b0;
      DOUBLE_P <= 1'b0;
      TRIPLE_P <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (KEY_P) begin
            state <= ONE;
          end
        end
        ONE: begin
          if (KEY_P) begin
            state   <= TWO;
            gap_cnt <= '0;
          end else if (gap_done) begin
            SINGLE_P <= 1'b1;
            state    <= IDLE;
            gap_cnt  <= '0;
          end else if (MS_F) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        TWO: begin
          // A third click closes the group at once.
          if (KEY_P) begin
            TRIPLE_P <= 1'b1;
            state    <= IDLE;
            gap_cnt  <= '0;
          end else if (gap_done) begin
            DOUBLE_P <= 1'b1;
            state    <= IDLE;
            gap_cnt  <= '0;
          end else if (MS_F) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_click_dec.sv
// Scoreboard bench for pb_click_dec: expected gesture pulses (kind, cycle)
// are queued when clicks are driven and matched as the DUT emits them.
module tb_pb_click_dec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key = 1'b0;
  logic tie_hi = 1'b0;
  logic ms_f;
  logic single, double, triple, busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t sb[$];

  pb_click_dec #(.GAP_MS(5), .CNT_W(9)) dut (
    .SYS_CLK (clk),
    .SYS_RST (rst),
    .MS_F    (ms_f),
    .KEY_P   (key),
    .SINGLE_P(single),
    .DOUBLE_P(double),
    .TRIPLE_P(triple),
    .BUSY    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ms_f = tie_hi | ((cyc % 10) == 9);

  // Pulse monitor: every observed pulse must match the queue head.
  always @(negedge clk) begin : mon
    int n;
    int kind;
    ev_t e;
    n = int'(single) + int'(double) + int'(triple);
    kind = single ? 1 : (double ? 2 : 3);
    if (n != 0) begin
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL multi_pulse cyc=%0d got s=%b d=%b t=%b want one",
                 cyc, single, double, triple);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got kind=%0d want none",
                 cyc, kind);
      end else begin
        e = sb.pop_front();
        if (e.kind !== kind || e.cyc !== cyc) begin
          errors++;
          $display("FAIL pulse got kind=%0d cyc=%0d want kind=%0d cyc=%0d",
                   kind, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  function automatic bit tick(int c);
    return tie_hi || ((c % 10) == 9);
  endfunction

  // Cycle of the 5th counted tick strictly after click cycle k.
  function automatic int fifth_tick(int k);
    int c = k;
    int n = 0;
    while (n < 5) begin
      c++;
      if (tick(c)) n++;
    end
    return c;
  endfunction

  function automatic int tmo(int k);
    return fifth_tick(k) + 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  task automatic key_at(int c);
    wait_until(c);
    key = 1'b1;
    step();
    key = 1'b0;
  endtask

  task automatic push(int kind, int c);
    ev_t e;
    e.kind = kind;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk_busy(string name, logic want);
    checks++;
    if (busy !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got busy=%b want %b", name, cyc, busy, want);
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    repeat (10) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int k;
    repeat (3) step();
    checks++;
    if ({single, double, triple, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_state got %b want 0000",
               {single, double, triple, busy});
    end
    rst = 1'b0;
    k = cyc + 2;
    key_at(k);
    chk_busy("reset_busy_open", 1'b1);
    wait_until(k + 20);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({single, double, triple, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_async got %b want 0000",
               {single, double, triple, busy});
    end
    step();
    step();
    rst = 1'b0;
    repeat (80) step();
    chk_busy("reset_discard", 1'b0);
  endtask

  task automatic test_single();
    int k = cyc + 2;
    int e = tmo(k);
    push(1, e);
    key_at(k);
    chk_busy("single_busy", 1'b1);
    wait_until(e - 1);
    chk_busy("single_busy_pre", 1'b1);
    step();
    chk_busy("single_busy_fall", 1'b0);
    drain("single");
  endtask

  task automatic test_double();
    int k1 = cyc + 2;
    int k2 = k1 + 30;
    int e = tmo(k2);
    push(2, e);
    key_at(k1);
    key_at(k2);
    wait_until(e - 1);
    chk_busy("double_busy_pre", 1'b1);
    step();
    chk_busy("double_busy_fall", 1'b0);
    drain("double");
  endtask

  task automatic test_triple();
    int b = cyc + 2;
    push(3, b + 51);
    push(1, tmo(b + 60));
    key_at(b);
    key_at(b + 25);
    key_at(b + 50);
    chk_busy("triple_busy_fall", 1'b0);
    key_at(b + 60);
    chk_busy("fourth_busy", 1'b1);
    drain("triple");
  endtask

  task automatic test_boundary();
    int k1 = cyc + 2;
    int kb = fifth_tick(k1) + 1;
    int p;
    push(2, tmo(kb));
    key_at(k1);
    key_at(kb);
    drain("bound_exact");
    k1 = cyc + 2;
    p = tmo(k1);
    push(1, p);
    push(1, tmo(p + 1));
    key_at(k1);
    key_at(p + 1);
    drain("bound_after");
  endtask

  task automatic test_back_to_back();
    int k1 = cyc + 2;
    int p = tmo(k1);
    push(1, p);
    push(1, tmo(p));
    key_at(k1);
    key_at(p);
    chk_busy("b2b_busy", 1'b1);
    drain("b2b");
  endtask

  task automatic test_coincide();
    int k = cyc + 2;
    while ((k % 10) != 9) k++;
    push(1, tmo(k));
    key_at(k);
    drain("coincide");
    tie_hi = 1'b1;
    k = cyc + 2;
    push(1, k + 7);
    key_at(k);
    drain("tied_high");
    tie_hi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_triple();
    test_boundary();
    test_back_to_back();
    test_coincide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
